// File: rtl/regfile_sb_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Register count and counter width are derived from the address width.
package regfile_sb_pkg;
    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int ZERO_ADDR      = 0;

    function automatic int num_regs(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One extra bit so the counter can hold NUM_REGS itself.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Write and issue enables are masked when they target the hardwired zero register.
    function automatic logic eff_en(input logic en, input logic is_zero, input logic zero_reg);
        return en & ~(zero_reg & is_zero);
    endfunction
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a count of busy registers.
// Provides RAW (busyN) and WAW (issue_conflict) hazard indications to the controller.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                issue_valid,
    input  logic [ADDR_WIDTH-1:0]               issue_addr,
    input  logic                                reg_write,
    input  logic [ADDR_WIDTH-1:0]               write_addr,
    input  logic [ADDR_WIDTH-1:0]               read_addr1,
    input  logic [ADDR_WIDTH-1:0]               read_addr2,
    output logic                                busy1,
    output logic                                busy2,
    output logic                                issue_conflict,
    output logic [cnt_width(ADDR_WIDTH)-1:0]    pending_count
);
    localparam int NUM_REGS = num_regs(ADDR_WIDTH);
    localparam int CW       = cnt_width(ADDR_WIDTH);

    logic [NUM_REGS-1:0] busy;
    logic set_en, clr_en, inc, dec;

    // A writeback landing on the same register this cycle retires the old producer.
    assign issue_conflict = issue_valid & busy[issue_addr]
                          & ~(reg_write & (write_addr == issue_addr));
    assign set_en = eff_en(issue_valid & ~issue_conflict,
                           issue_addr == ADDR_WIDTH'(ZERO_ADDR), ZERO_REG);
    assign clr_en = eff_en(reg_write, write_addr == ADDR_WIDTH'(ZERO_ADDR), ZERO_REG);

    // Same-address set+clear leaves the bit set, so neither edge of the count moves.
    assign inc = set_en & ~busy[issue_addr];
    assign dec = clr_en & busy[write_addr] & ~(set_en & (issue_addr == write_addr));

    assign busy1 = busy[read_addr1] & ~(BYPASS & reg_write & (write_addr == read_addr1));
    assign busy2 = busy[read_addr2] & ~(BYPASS & reg_write & (write_addr == read_addr2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy          <= '0;
            pending_count <= '0;
        end else begin
            if (clr_en) busy[write_addr] <= 1'b0;
            if (set_en) busy[issue_addr] <= 1'b1;
            pending_count <= pending_count + CW'(inc) - CW'(dec);
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with optional zero register, write bypass
// and a pending-write scoreboard for hazard detection.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [WIDTH-1:0]      writeData,
    input  logic [ADDR_WIDTH-1:0] readAddr1,
    input  logic [ADDR_WIDTH-1:0] readAddr2,
    output logic [WIDTH-1:0]      readData1,
    output logic [WIDTH-1:0]      readData2,
    input  logic                  issueValid,
    input  logic [ADDR_WIDTH-1:0] issueAddr,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  issueConflict,
    output logic [ADDR_WIDTH:0]   pendingCount
);
    localparam int NUM_REGS = num_regs(ADDR_WIDTH);

    logic [WIDTH-1:0] mem [NUM_REGS];
    logic             wr_en;

    assign wr_en = eff_en(regWrite, writeAddr == ADDR_WIDTH'(ZERO_ADDR), ZERO_REG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[writeAddr] <= writeData;
        end
    end

    // Zero-register masking is applied last so it overrides the bypass path.
    always_comb begin
        readData1 = mem[readAddr1];
        if (BYPASS && regWrite && writeAddr == readAddr1) readData1 = writeData;
        if (ZERO_REG && readAddr1 == ADDR_WIDTH'(ZERO_ADDR)) readData1 = '0;
        readData2 = mem[readAddr2];
        if (BYPASS && regWrite && writeAddr == readAddr2) readData2 = writeData;
        if (ZERO_REG && readAddr2 == ADDR_WIDTH'(ZERO_ADDR)) readData2 = '0;
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_sb (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issueValid),
        .issue_addr     (issueAddr),
        .reg_write      (regWrite),
        .write_addr     (writeAddr),
        .read_addr1     (readAddr1),
        .read_addr2     (readAddr2),
        .busy1          (busy1),
        .busy2          (busy2),
        .issue_conflict (issueConflict),
        .pending_count  (pendingCount)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: three configurations share one stimulus stream
// (a: zero reg + bypass, b: zero reg, no bypass, c: no zero reg, bypass).
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        regWrite = 1'b0;
    logic        issueValid = 1'b0;
    logic [4:0]  writeAddr = '0, readAddr1 = '0, readAddr2 = '0, issueAddr = '0;
    logic [31:0] writeData = '0;

    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;
    logic        a_b1, a_b2, a_cf, b_b1, b_b2, b_cf, c_b1, c_b2, c_cf;
    logic [5:0]  a_cnt, b_cnt, c_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_sb dut_a (
        .clk(clk), .reset(reset), .regWrite(regWrite), .writeAddr(writeAddr),
        .writeData(writeData), .readAddr1(readAddr1), .readAddr2(readAddr2),
        .readData1(a_rd1), .readData2(a_rd2), .issueValid(issueValid),
        .issueAddr(issueAddr), .busy1(a_b1), .busy2(a_b2),
        .issueConflict(a_cf), .pendingCount(a_cnt));

    regfile_sb #(.BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .regWrite(regWrite), .writeAddr(writeAddr),
        .writeData(writeData), .readAddr1(readAddr1), .readAddr2(readAddr2),
        .readData1(b_rd1), .readData2(b_rd2), .issueValid(issueValid),
        .issueAddr(issueAddr), .busy1(b_b1), .busy2(b_b2),
        .issueConflict(b_cf), .pendingCount(b_cnt));

    regfile_sb #(.ZERO_REG(1'b0)) dut_c (
        .clk(clk), .reset(reset), .regWrite(regWrite), .writeAddr(writeAddr),
        .writeData(writeData), .readAddr1(readAddr1), .readAddr2(readAddr2),
        .readData1(c_rd1), .readData2(c_rd2), .issueValid(issueValid),
        .issueAddr(issueAddr), .busy1(c_b1), .busy2(c_b2),
        .issueConflict(c_cf), .pendingCount(c_cnt));

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1, r2;
        logic        iv;
        logic [4:0]  ia;
        logic [31:0] e_rd1, e_rd2;
        logic        e_b1, e_b2, e_cf;
        logic [5:0]  e_cnt;
    } vec_t;
    vec_t vt[12];

    task automatic expect_v(input string n, input logic [31:0] e);
        exp_t x;
        x.name = n;
        x.exp  = e;
        sbq.push_back(x);
    endtask

    task automatic got(input logic [31:0] act);
        exp_t x;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow actual=%h required=<queued expectation>", act);
        end else begin
            x = sbq.pop_front();
            if (act !== x.exp) begin
                failures++;
                $display("FAIL %s actual=%h required=%h", x.name, act, x.exp);
            end
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic iv, input logic [4:0] ia);
        regWrite   = we;
        writeAddr  = wa;
        writeData  = wd;
        readAddr1  = r1;
        readAddr2  = r2;
        issueValid = iv;
        issueAddr  = ia;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b0, 5'd0, 32'h0, r1, r2, 1'b0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            we    wa     wd            r1     r2     iv    ia     rd1           rd2           b1    b2    cf    cnt
        vt[0]  = '{1'b1, 5'd10, 32'hdeadbeef, 5'd10, 5'd0,  1'b0, 5'd0,  32'hdeadbeef, 32'h0,        1'b0, 1'b0, 1'b0, 6'd0};
        vt[1]  = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd10, 1'b0, 5'd0,  32'h0,        32'hdeadbeef, 1'b0, 1'b0, 1'b0, 6'd0};
        vt[2]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd10, 1'b1, 5'd0,  32'h0,        32'hdeadbeef, 1'b0, 1'b0, 1'b0, 6'd0};
        vt[3]  = '{1'b0, 5'd0,  32'h0,        5'd10, 5'd8,  1'b1, 5'd8,  32'hdeadbeef, 32'h0,        1'b0, 1'b0, 1'b0, 6'd1};
        vt[4]  = '{1'b0, 5'd0,  32'h0,        5'd10, 5'd8,  1'b1, 5'd9,  32'hdeadbeef, 32'h0,        1'b0, 1'b1, 1'b0, 6'd2};
        vt[5]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd8,  1'b1, 5'd8,  32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 6'd2};
        vt[6]  = '{1'b1, 5'd8,  32'h00000055, 5'd8,  5'd9,  1'b1, 5'd8,  32'h00000055, 32'h0,        1'b0, 1'b1, 1'b0, 6'd2};
        vt[7]  = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd9,  1'b0, 5'd0,  32'h00000055, 32'h0,        1'b1, 1'b1, 1'b0, 6'd2};
        vt[8]  = '{1'b1, 5'd8,  32'h00000066, 5'd8,  5'd3,  1'b0, 5'd0,  32'h00000066, 32'h0,        1'b0, 1'b0, 1'b0, 6'd1};
        vt[9]  = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd9,  1'b0, 5'd0,  32'h00000066, 32'h0,        1'b0, 1'b1, 1'b0, 6'd1};
        vt[10] = '{1'b1, 5'd9,  32'h00000077, 5'd9,  5'd10, 1'b0, 5'd0,  32'h00000077, 32'hdeadbeef, 1'b0, 1'b0, 1'b0, 6'd0};
        vt[11] = '{1'b1, 5'd9,  32'h00000078, 5'd9,  5'd8,  1'b0, 5'd0,  32'h00000078, 32'h00000066, 1'b0, 1'b0, 1'b0, 6'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        expect_v("rst_a_rd1", 32'h0);   got(a_rd1);
        expect_v("rst_c_rd1", 32'h0);   got(c_rd1);
        expect_v("rst_a_cnt", 32'd0);   got(32'(a_cnt));
        expect_v("rst_c_b1", 32'd0);    got(32'(c_b1));
        reset = 1'b0;

        // Table of main-function vectors on configuration a
        for (int i = 0; i < 12; i++) begin
            step();
            drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].r1, vt[i].r2, vt[i].iv, vt[i].ia);
            expect_v($sformatf("v%0d_rd1", i), vt[i].e_rd1);
            expect_v($sformatf("v%0d_rd2", i), vt[i].e_rd2);
            expect_v($sformatf("v%0d_busy1", i), 32'(vt[i].e_b1));
            expect_v($sformatf("v%0d_busy2", i), 32'(vt[i].e_b2));
            expect_v($sformatf("v%0d_conflict", i), 32'(vt[i].e_cf));
            #1;
            got(a_rd1); got(a_rd2); got(32'(a_b1)); got(32'(a_b2)); got(32'(a_cf));
            expect_v($sformatf("v%0d_count", i), 32'(vt[i].e_cnt));
            @(posedge clk);
            #1;
            got(32'(a_cnt));
            idle(5'd0, 5'd0);
        end

        // r0 is a real register without ZERO_REG; the issue to r0 counted only there
        step();
        idle(5'd0, 5'd0);
        #1;
        expect_v("zr_a_rd1", 32'h0);         got(a_rd1);
        expect_v("zr_c_rd1", 32'h00001234);  got(c_rd1);
        expect_v("zr_a_cnt", 32'd0);         got(32'(a_cnt));
        expect_v("zr_c_cnt", 32'd1);         got(32'(c_cnt));

        // Bypass vs no bypass on a busy register
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd0, 1'b1, 5'd10);
        step();
        drive(1'b1, 5'd10, 32'hcafef00d, 5'd10, 5'd0, 1'b0, 5'd0);
        #1;
        expect_v("byp_a_rd1", 32'hcafef00d); got(a_rd1);
        expect_v("byp_b_rd1", 32'hdeadbeef); got(b_rd1);
        expect_v("byp_a_busy1", 32'd0);      got(32'(a_b1));
        expect_v("byp_b_busy1", 32'd1);      got(32'(b_b1));
        step();
        idle(5'd10, 5'd0);
        #1;
        expect_v("nobyp_b_rd1", 32'hcafef00d); got(b_rd1);
        expect_v("nobyp_b_busy1", 32'd0);      got(32'(b_b1));
        expect_v("nobyp_b_cnt", 32'd0);        got(32'(b_cnt));

        // Asynchronous reset mid-cycle with data and three busy registers
        step();
        drive(1'b1, 5'd5, 32'h00000abc, 5'd0, 5'd0, 1'b1, 5'd1);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd2);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd3);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd1, 1'b1, 5'd2);
        #1;
        expect_v("pre_rst_cnt", 32'd3);         got(32'(a_cnt));
        expect_v("pre_rst_rd1", 32'h00000abc);  got(a_rd1);
        expect_v("pre_rst_busy2", 32'd1);       got(32'(a_b2));
        expect_v("pre_rst_conflict", 32'd1);    got(32'(a_cf));
        #2;
        reset = 1'b1;
        #1;
        expect_v("arst_rd1", 32'h0);      got(a_rd1);
        expect_v("arst_busy2", 32'd0);    got(32'(a_b2));
        expect_v("arst_cnt", 32'd0);      got(32'(a_cnt));
        expect_v("arst_conflict", 32'd0); got(32'(a_cf));
        expect_v("arst_c_cnt", 32'd0);    got(32'(c_cnt));
        idle(5'd0, 5'd0);
        step();
        reset = 1'b0;

        // Fill every register busy, then drain, on configuration c
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'(i));
            expect_v($sformatf("fill%0d_cnt", i), 32'(i + 1));
            step();
            got(32'(c_cnt));
        end
        expect_v("fill_a_cnt", 32'd31); got(32'(a_cnt));
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd7);
        #1;
        expect_v("full_conflict", 32'd1); got(32'(c_cf));
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 1'b0, 5'd0);
            expect_v($sformatf("drain%0d_cnt", i), 32'(31 - i));
            step();
            got(32'(c_cnt));
        end
        drive(1'b1, 5'd5, 32'h5, 5'd0, 5'd0, 1'b0, 5'd0);
        expect_v("extra_write_cnt", 32'd0);
        step();
        got(32'(c_cnt));
        idle(5'd0, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the datapath register file: 2 async read ports and 1 sync write port, generalised in width and depth.
- Adds an optional hardwired zero register and optional write-to-read bypass.
- Adds a per-register pending-write scoreboard so the multicycle/pipelined controller can detect RAW and WAW hazards.
- Sits in the datapath between decode (issue/read) and writeback (write).

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_WIDTH, 5, address width; depth NUM_REGS = 1<<ADDR_WIDTH.
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never marked busy.
- BYPASS, 1, when 1, a read of the address being written this cycle returns writeData, and the matching busy output is suppressed.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all registers, busy bits and the counter.
- regWrite  in  1  writeback strobe.
- writeAddr  in  ADDR_WIDTH  writeback register.
- writeData  in  WIDTH  writeback data.
- readAddr1, readAddr2  in  ADDR_WIDTH  operand addresses.
- readData1, readData2  out  WIDTH  operand data, combinational.
- issueValid  in  1  instruction issued; mark issueAddr pending.
- issueAddr  in  ADDR_WIDTH  destination of the issued instruction.
- busy1, busy2  out  1  operand register has a pending write (RAW hazard), combinational.
- issueConflict  out  1  issueValid and issueAddr already busy (WAW), combinational.
- pendingCount  out  ADDR_WIDTH+1  number of busy registers.

Behaviour:
- Reset, asserted asynchronously at any time including mid-operation:
  - all registers become 0, all busy bits become 0, pendingCount becomes 0.
  - Outputs then read 0, busy1/busy2 read 0, and issueConflict reflects only current inputs.
- Read:
  - readDataN = MEM[readAddrN], zero-latency.
  - If ZERO_REG and readAddrN==0, output 0.
  - If BYPASS and regWrite and writeAddr==readAddrN (and not the zero register), output writeData.
- Write:
  - At posedge with regWrite, MEM[writeAddr] <= writeData.
  - Dropped if ZERO_REG and writeAddr==0.
  - Write also clears busy[writeAddr].
- Issue:
  - At posedge with issueValid and not issueConflict, busy[issueAddr] <= 1.
  - Ignored when ZERO_REG and issueAddr==0.
- issueConflict = issueValid & busy[issueAddr] & ~(regWrite & writeAddr==issueAddr).
  - A same-cycle writeback to that register resolves the conflict.
  - An issue that is still in conflict is ignored entirely: no state change. The controller must stall and re-present it.
- Simultaneous issue and write to the same address: data is written and busy ends at 1 (new issue wins); pendingCount is unchanged.
- Write to a non-busy register: busy stays 0 and the counter does not decrement (no underflow).
- busyN = busy[readAddrN] & ~(BYPASS & regWrite & writeAddr==readAddrN).
  - Always 0 for the zero register when ZERO_REG.
- pendingCount next value = current + (effective set of a non-busy register) − (clear of a busy register).
  - Range 0..NUM_REGS (NUM_REGS−1 when ZERO_REG); never wraps.
- No $display side effects in synthesizable paths; debug prints are guarded by an ifdef.

Decomposition:
- Shared package holds:
  - NUM_REGS derived from ADDR_WIDTH;
  - the count width (ADDR_WIDTH+1);
  - the ZERO_ADDR constant;
  - a function giving the effective write/issue enables (zero-register masking).
- One natural sub-module, regfile_scoreboard, contains:
  - the busy vector;
  - pendingCount;
  - the conflict/busy logic (inputs: issue, write, and the two read addresses).
- The top keeps the storage array and the read/bypass muxes.

Test Plan:
- Reset pulse mid-cycle while regs hold data and 3 registers are busy -> immediately readData=0, busy=0, pendingCount=0 with no clock edge.
- Write 32'hdeadbeef to r10 with readAddr1=10 in the same cycle -> BYPASS=1 gives readData1=deadbeef that cycle; BYPASS=0 gives the old value, then deadbeef the next cycle.
- Write 32'h1234 to r0 with ZERO_REG=1 -> readData=0 after the edge; issue to r0 leaves pendingCount=0.
- Issue r8, then r9 on consecutive cycles -> pendingCount 1, then 2. readAddr2=8 gives busy2=1. Write r8 -> busy2=0 and pendingCount=1 after the edge.
- With r8 busy, issue r8 -> issueConflict=1 and no count change. Re-issue r8 while regWrite to r8 in the same cycle -> issueConflict=0, data written, busy[8]=1, pendingCount unchanged.
- Fill all registers busy (ZERO_REG=0), then write each one -> pendingCount reaches 32 without wrapping and returns to 0. An extra write to a non-busy register keeps it at 0.
